// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
//
// SPI mode-0 slave that receives fixed-length command frames from the MCU and
// presents each completed frame to the game/state logic as a one-cycle
// handshake. sck, sdi and ce are oversampled in the HSOSC_clk domain. A
// full-duplex reply word is shifted out on sdo during the same frame.
//
// Ports
//   HSOSC_clk   in   system clock, all logic synchronous to it
//   reset_n     in   async active-low reset (release synchronised internally)
//   sck         in   SPI clock, CPOL=0 / CPHA=0, asynchronous
//   sdi         in   SPI data from MCU, asynchronous
//   ce          in   chip enable, active high; one frame per ce-high interval
//   sdo         out  SPI reply data to MCU
//   tx_data     in   reply word, captured at frame start
//   frame_data  out  last good received frame
//   frame_valid out  one-cycle pulse when frame_data updates
//   frame_error out  one-cycle pulse on a frame of the wrong length
//   frame_count out  good-frame counter, wraps modulo 2^COUNT_BITS
//   busy        out  high while a frame is being shifted
//
// state | meaning
// ------+-----------------------------------------------------------------
// ARM   | after reset: wait for synchronisers to fill and ce to be seen low
// IDLE  | waiting for a ce rising edge
// SHIFT | frame in progress: sample sdi on sck rise, advance sdo on sck fall
// DONE  | one cycle: judge frame length, pulse frame_valid or frame_error
// -----------------------------------------------------------------------------
module spi_frame_receiver #(
  parameter int FRAME_BYTES = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1,
  parameter int COUNT_BITS  = 8
) (
  input  logic                     HSOSC_clk,
  input  logic                     reset_n,
  input  logic                     sck,
  input  logic                     sdi,
  input  logic                     ce,
  output logic                     sdo,
  input  logic [FRAME_BYTES*8-1:0] tx_data,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_error,
  output logic [COUNT_BITS-1:0]    frame_count,
  output logic                     busy
);

  localparam int N  = FRAME_BYTES * 8;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reset: asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_int_n = rst_pipe[1];

  // Input synchronisers plus one extra flop for edge detection.
  logic [SYNC_STAGES-1:0] sck_pipe, sdi_pipe, ce_pipe;
  logic                   sck_d, ce_d;
  logic                   sck_s, sdi_s, ce_s;
  logic                   sck_rise, sck_fall, ce_rise, ce_fall;

  always_ff @(posedge HSOSC_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sck_pipe <= '0;
      sdi_pipe <= '0;
      ce_pipe  <= '0;
      sck_d    <= 1'b0;
      ce_d     <= 1'b0;
    end else begin
      sck_pipe <= {sck_pipe[SYNC_STAGES-2:0], sck};
      sdi_pipe <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
      ce_pipe  <= {ce_pipe[SYNC_STAGES-2:0], ce};
      sck_d    <= sck_pipe[SYNC_STAGES-1];
      ce_d     <= ce_pipe[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_pipe[SYNC_STAGES-1];
  assign sdi_s    = sdi_pipe[SYNC_STAGES-1];
  assign ce_s     = ce_pipe[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ce_rise  = ce_s & ~ce_d;
  assign ce_fall  = ~ce_s & ce_d;

  state_t          state;
  logic [AW-1:0]   arm_tmr;
  logic [N-1:0]    rx_sh;
  logic [N-1:0]    tx_sh;
  logic [CW-1:0]   bit_cnt;
  logic            ovf;
  logic            ce_pend;

  always_ff @(posedge HSOSC_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ARM;
      arm_tmr     <= AW'(SYNC_STAGES);
      rx_sh       <= '0;
      tx_sh       <= '0;
      bit_cnt     <= '0;
      ovf         <= 1'b0;
      ce_pend     <= 1'b0;
      sdo         <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        // The synchronisers come out of reset holding 0, so ce_s is only
        // trusted once the timer has let the pipeline fill with real samples.
        ARM: begin
          if (arm_tmr != '0)  arm_tmr <= arm_tmr - 1'b1;
          else if (!ce_s)     state   <= IDLE;
        end

        IDLE: begin
          ce_pend <= 1'b0;
          if (ce_rise || ce_pend) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            ovf     <= 1'b0;
            tx_sh   <= tx_data;
            sdo     <= (MSB_FIRST != 0) ? tx_data[N-1] : tx_data[0];
          end
        end

        SHIFT: begin
          if (ce_fall) begin
            state <= DONE;
            busy  <= 1'b0;
          end else if (sck_rise) begin
            if (bit_cnt == CW'(N)) begin
              ovf <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              if (MSB_FIRST != 0) rx_sh <= {rx_sh[N-2:0], sdi_s};
              else                rx_sh <= {sdi_s, rx_sh[N-1:1]};
            end
          end else if (sck_fall) begin
            // Zero fill means sdo naturally drops to 0 once all N bits are out.
            if (MSB_FIRST != 0) begin
              tx_sh <= {tx_sh[N-2:0], 1'b0};
              sdo   <= tx_sh[N-2];
            end else begin
              tx_sh <= {1'b0, tx_sh[N-1:1]};
              sdo   <= tx_sh[1];
            end
          end
        end

        DONE: begin
          state <= IDLE;
          sdo   <= 1'b0;
          // A ce rise seen here would otherwise be lost before IDLE looks.
          if (ce_rise) ce_pend <= 1'b1;
          if ((bit_cnt == CW'(N)) && !ovf) begin
            frame_data  <= rx_sh;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
//
// Drives SPI mode-0 frames into two receivers sharing the same bus, one MSB
// first and one LSB first. Each frame pushes its expected outcome onto a
// per-instance queue; monitors pop and compare whenever a frame pulse appears.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

  localparam int HP  = 4;   // sck half period in system clocks
  localparam int GAP = 8;   // ce low time between frames

  typedef struct {
    logic        err;
    logic [15:0] data;
    logic [7:0]  count;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sck, sdi, ce;
  logic [15:0] tx;

  logic        sdo, frame_valid, frame_error, busy;
  logic [15:0] frame_data;
  logic [7:0]  frame_count;

  logic        sdo_lsb, frame_valid_lsb, frame_error_lsb, busy_lsb;
  logic [15:0] frame_data_lsb;
  logic [7:0]  frame_count_lsb;

  exp_t        q_msb[$];
  exp_t        q_lsb[$];
  logic [15:0] exp_data, exp_data_lsb;
  logic [7:0]  exp_count;

  int n_chk  = 0;
  int n_fail = 0;

  spi_frame_receiver #(
    .FRAME_BYTES(2), .SYNC_STAGES(2), .MSB_FIRST(1), .COUNT_BITS(8)
  ) dut (
    .HSOSC_clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce),
    .sdo(sdo), .tx_data(tx), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_count(frame_count), .busy(busy)
  );

  spi_frame_receiver #(
    .FRAME_BYTES(2), .SYNC_STAGES(2), .MSB_FIRST(0), .COUNT_BITS(8)
  ) dut_lsb (
    .HSOSC_clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce),
    .sdo(sdo_lsb), .tx_data(tx), .frame_data(frame_data_lsb),
    .frame_valid(frame_valid_lsb), .frame_error(frame_error_lsb),
    .frame_count(frame_count_lsb), .busy(busy_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && (frame_valid || frame_error)) begin
      if (q_msb.size() == 0) begin
        chk("msb_unexpected_pulse", 32'(frame_valid | frame_error), 32'd0);
      end else begin
        exp_t e;
        e = q_msb.pop_front();
        chk("msb_error_flag", 32'(frame_error), 32'(e.err));
        chk("msb_valid_flag", 32'(frame_valid), 32'(!e.err));
        chk("msb_frame_data", 32'(frame_data), 32'(e.data));
        chk("msb_frame_count", 32'(frame_count), 32'(e.count));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && (frame_valid_lsb || frame_error_lsb)) begin
      if (q_lsb.size() == 0) begin
        chk("lsb_unexpected_pulse", 32'(frame_valid_lsb | frame_error_lsb), 32'd0);
      end else begin
        exp_t e;
        e = q_lsb.pop_front();
        chk("lsb_error_flag", 32'(frame_error_lsb), 32'(e.err));
        chk("lsb_frame_data", 32'(frame_data_lsb), 32'(e.data));
        chk("lsb_frame_count", 32'(frame_count_lsb), 32'(e.count));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sdo"},   32'(sdo), 32'd0);
    chk({tag, "_data"},  32'(frame_data), 32'd0);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_error"}, 32'(frame_error), 32'd0);
    chk({tag, "_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Sends nbits of w MSB first on the wire; the MCU side captures sdo of both
  // instances on each sck rise. rst_at >= 0 pulses reset before that bit.
  task automatic send_frame(input logic [31:0] w, input int nbits, input int rst_at,
                            output logic [15:0] miso, output logic [15:0] miso_lsb);
    miso     = '0;
    miso_lsb = '0;
    ce = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        wait_clk(2);
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
      end
      sdi = w[nbits-1-i];
      wait_clk(HP);
      sck = 1'b1;
      if (i < 16) begin
        miso[15-i]  = sdo;
        miso_lsb[i] = sdo_lsb;
      end
      if (i == 0) begin
        chk("busy_msb", 32'(busy), 32'd1);
        chk("busy_lsb", 32'(busy_lsb), 32'd1);
      end
      wait_clk(HP);
      sck = 1'b0;
    end
    wait_clk(HP);
    if (nbits == 16 && rst_at < 0) chk("sdo_after_last_bit", 32'(sdo), 32'd0);
    ce  = 1'b0;
    sdi = 1'b0;
    wait_clk(GAP);
    chk("sdo_after_ce_fall", 32'(sdo), 32'd0);
    chk("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic frame(input logic [31:0] w, input int nbits, input int rst_at,
                       output logic [15:0] miso, output logic [15:0] miso_lsb);
    exp_t e, el;
    if (rst_at >= 0) begin
      exp_data     = '0;
      exp_data_lsb = '0;
      exp_count    = '0;
    end else if (nbits == 16) begin
      exp_data     = w[15:0];
      exp_data_lsb = rev16(w[15:0]);
      exp_count    = exp_count + 8'd1;
      e.err = 1'b0; e.data = exp_data;     e.count = exp_count;
      el.err = 1'b0; el.data = exp_data_lsb; el.count = exp_count;
      q_msb.push_back(e);
      q_lsb.push_back(el);
    end else begin
      e.err = 1'b1; e.data = exp_data;     e.count = exp_count;
      el.err = 1'b1; el.data = exp_data_lsb; el.count = exp_count;
      q_msb.push_back(e);
      q_lsb.push_back(el);
    end
    send_frame(w, nbits, rst_at, miso, miso_lsb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] m, ml;
    reset_n = 1'b0;
    sck = 1'b0; sdi = 1'b0; ce = 1'b0; tx = '0;
    exp_data = '0; exp_data_lsb = '0; exp_count = '0;
    wait_clk(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clk(10);

    tx = 16'h1111;
    frame(32'hA55A, 16, -1, m, ml);
    chk("count_after_a55a", 32'(frame_count), 32'd1);
    chk("data_after_a55a", 32'(frame_data), 32'hA55A);

    tx = 16'h3C96;
    frame(32'h0000, 16, -1, m, ml);
    chk("tx_word_msb", 32'(m), 32'h3C96);

    tx = 16'h0000;
    frame(32'h1234, 16, -1, m, ml);
    frame(32'h0ABC, 12, -1, m, ml);
    frame(32'h15555, 17, -1, m, ml);
    chk("data_hold_after_errors", 32'(frame_data), 32'h1234);
    chk("count_hold_after_errors", 32'(frame_count), 32'(exp_count));

    frame(32'hBEEF, 16, 8, m, ml);
    frame(32'h0F0F, 16, -1, m, ml);
    chk("data_after_reset_frame", 32'(frame_data), 32'h0F0F);
    chk("count_after_reset_frame", 32'(frame_count), 32'd1);

    tx = 16'h8001;
    frame(32'h8000, 16, -1, m, ml);
    chk("lsb_first_bit0", 32'(frame_data_lsb[0]), 32'd1);
    chk("lsb_tx_word", 32'(ml), 32'h8001);

    reset_n = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    exp_data = '0; exp_data_lsb = '0; exp_count = '0;
    wait_clk(10);
    tx = 16'h5A5A;
    for (int k = 0; k < 256; k++) begin
      frame(32'($urandom_range(0, 65535)), 16, -1, m, ml);
      if (k == 254) chk("count_before_wrap", 32'(frame_count), 32'd255);
    end
    chk("count_wrap", 32'(frame_count), 32'd0);

    wait_clk(20);
    chk("msb_queue_drained", 32'(q_msb.size()), 32'd0);
    chk("lsb_queue_drained", 32'(q_lsb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
